alu_mul_seq: RTL and testbench

Multi-cycle 16-bit multiplier sequencer built on the shared Hack-style combinational ALU. It holds the multiply operands and accumulator, and each cycle drives the ALU's x/y operands and six control bits. It captures the ALU result back into its registers, computing the low 16 bits of a×b by shift-and-add in a fixed 33-cycle sequence. The block sits beside the ALU and owns it while busy; the ALU instance itself is external, connected through the alu_* ports.

---
 rtl/alu_mul_seq.sv | 125 ++++++++++++
 tb/tb_alu_mul_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Sequential 16-bit multiplier. It computes the low 16 bits of a*b by
//   shift-and-add and routes every addition through an external Hack-style
//   combinational ALU.
//
//   A run has a fixed length. After start is accepted, the block alternates
//   ADD / DBL for 16 bit positions (32 cycles), then spends one DONE cycle,
//   then returns to IDLE.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   start              request, honoured only in IDLE
//   a, b               multiplicand / multiplier, captured on accepted start
//   busy               high in every state except IDLE
//   done               one-cycle pulse in the DONE state
//   product            accumulator; final value from DONE until next start
//   alu_x, alu_y       operands driven to the external ALU
//   alu_zx..alu_no     ALU control bits
//   alu_out            ALU result, combinational from the signals above
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out
);

    typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} stateT;

    stateT       state;
    stateT       nextState;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;

    assign product = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                // ALU either adds mcand or passes acc through unchanged
                ADD: acc <= alu_out;
                // mcand doubles via mcand+mcand in the ALU; the multiplier
                // shift is done locally because the ALU has no shifter
                DBL: begin
                    mcand  <= alu_out;
                    mplier <= {1'b0, mplier[15:1]};
                    if (cnt != 4'd15) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        alu_x     = '0;
        alu_y     = '0;
        alu_zx    = 1'b0;
        alu_nx    = 1'b0;
        alu_zy    = 1'b0;
        alu_ny    = 1'b0;
        alu_f     = 1'b0;
        alu_no    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = ADD;
                end
            end
            ADD: begin
                alu_x = acc;
                alu_y = mcand;
                if (mplier[0]) begin
                    alu_f = 1'b1;               // x + y
                end else begin
                    alu_zy = 1'b1;              // y forced to all-ones,
                    alu_ny = 1'b1;              // then x & y = x
                end
                nextState = DBL;
            end
            DBL: begin
                alu_x     = mcand;
                alu_y     = mcand;
                alu_f     = 1'b1;
                nextState = (cnt == 4'd15) ? DONE : ADD;
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq. A behavioural Hack ALU is attached to the alu_*
// ports. Expected products come from plain 32-bit multiplication truncated
// to 16 bits.
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx;
    logic        alu_nx;
    logic        alu_zy;
    logic        alu_ny;
    logic        alu_f;
    logic        alu_no;
    logic [15:0] alu_out;

    int total = 0;
    int bad   = 0;

    alu_mul_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_zx  (alu_zx),
        .alu_nx  (alu_nx),
        .alu_zy  (alu_zy),
        .alu_ny  (alu_ny),
        .alu_f   (alu_f),
        .alu_no  (alu_no),
        .alu_out (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hack ALU
    logic [15:0] xz, yz, xn, yn, fo;
    always_comb begin
        xz      = alu_zx ? 16'h0 : alu_x;
        xn      = alu_nx ? ~xz : xz;
        yz      = alu_zy ? 16'h0 : alu_y;
        yn      = alu_ny ? ~yz : yz;
        fo      = alu_f ? (xn + yn) : (xn & yn);
        alu_out = alu_no ? ~fo : fo;
    end

    function automatic logic [15:0] mulRef(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0, x} * {16'h0, y};
        return p[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chkIdleOutputs(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_product"}, 32'(product), 32'd0);
        chk({nm, "_alux"}, 32'(alu_x), 32'd0);
        chk({nm, "_aluy"}, 32'(alu_y), 32'd0);
        chk({nm, "_ctl"}, 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
    endtask

    // One full multiply: start pulse, bounded wait for done, latency/result/hold checks.
    task automatic doMul(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [15:0] expP, input string nm);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        @(negedge clk);
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        chk({nm, "_busy1"}, 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd33);
        chk({nm, "_product"}, 32'(product), 32'(expP));
        @(negedge clk);
        chk({nm, "_donefall"}, 32'(done), 32'd0);
        chk({nm, "_busyfall"}, 32'(busy), 32'd0);
        chk({nm, "_hold"}, 32'(product), 32'(expP));
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] expP;
    } vecT;

    vecT vecs[5];

    initial begin
        logic [15:0] ra, rb;
        logic [15:0] opA[2];
        logic [15:0] opB[2];
        int doneCnt;
        logic sawDone;
        logic expDone, expBusy;
        logic [5:0] expCode;
        int j;

        vecs[0] = '{16'd3,    16'd5,    16'h000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[2] = '{16'hFFFD, 16'd7,    16'hFFEB};
        vecs[3] = '{16'd300,  16'd300,  16'h5F90};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000};

        reset = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (2) @(negedge clk);
        chkIdleOutputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            doMul(vecs[i].va, vecs[i].vb, vecs[i].expP, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            doMul(ra, rb, mulRef(ra, rb), $sformatf("rnd%0d", i));
        end

        // start held high with operands changing every cycle
        @(negedge clk);
        doneCnt = 0;
        opA[0] = 16'h0; opB[0] = 16'h0; opA[1] = 16'h0; opB[1] = 16'h0;
        for (int k = 0; k <= 68; k++) begin
            expDone = (k == 33) || (k == 67);
            expBusy = !((k == 0) || (k == 34) || (k == 68));
            chk($sformatf("hold_done_k%0d", k), 32'(done), 32'(expDone));
            chk($sformatf("hold_busy_k%0d", k), 32'(busy), 32'(expBusy));
            if (done) doneCnt++;
            if (k == 33) chk("hold_prod1", 32'(product), 32'(mulRef(opA[0], opB[0])));
            if (k == 67) chk("hold_prod2", 32'(product), 32'(mulRef(opA[1], opB[1])));
            start = (k < 68);
            a     = 16'($urandom);
            b     = 16'($urandom);
            if (k == 0)  begin opA[0] = a; opB[0] = b; end
            if (k == 34) begin opA[1] = a; opB[1] = b; end
            @(negedge clk);
        end
        start = 1'b0;
        chk("hold_donecount", 32'(doneCnt), 32'd2);

        // ALU control sequence with a=1, b=5
        @(negedge clk);
        start = 1'b1;
        a     = 16'd1;
        b     = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k % 2 == 1) begin
                j = (k - 1) / 2;
                expCode = ((16'h0005 >> j) & 16'h1) != 16'h0 ? 6'b000010 : 6'b001100;
                chk($sformatf("ctl_add_code_c%0d", k),
                    32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'(expCode));
                chk($sformatf("ctl_add_y_c%0d", k), 32'(alu_y), 32'(16'(32'd1 << j)));
                chk($sformatf("ctl_add_x_c%0d", k), 32'(alu_x),
                    32'(16'h0005 & 16'((32'd1 << j) - 1)));
            end else begin
                j = (k - 2) / 2;
                chk($sformatf("ctl_dbl_code_c%0d", k),
                    32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'b000010);
                chk($sformatf("ctl_dbl_xy_c%0d", k), 32'(alu_x), 32'(alu_y));
                chk($sformatf("ctl_dbl_x_c%0d", k), 32'(alu_x), 32'(16'(32'd1 << j)));
            end
            @(negedge clk);
        end
        chk("ctl_done", 32'(done), 32'd1);
        chk("ctl_product", 32'(product), 32'h0005);
        chk("ctl_done_ctl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
        @(negedge clk);

        // reset in cycle 10 of an operation
        @(negedge clk);
        start = 1'b1;
        a     = 16'h0055;
        b     = 16'h0077;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chkIdleOutputs("midreset");
        reset   = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        chk("midreset_nodone", 32'(sawDone), 32'd0);
        doMul(16'h1111, 16'h0003, 16'h3333, "postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
